// File: rtl/thresholding_stream_ctrl_if.sv
// Valid/ready stream bundle shared by the input and result sides of the
// thresholding stream controller.
interface thresholding_stream_ctrl_if #(
    parameter int unsigned W = 8
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    // Producer side of a stream
    modport master (output tvalid, output tdata, input tready);
    // Consumer side of a stream
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/thresholding_stream_ctrl.sv
// AXI-Stream wrapper around a free-running, fixed-latency thresholding core.
// Input beats are admitted only while a result slot is guaranteed, so every
// core result always finds room in the output FIFO.
module thresholding_stream_ctrl #(
    parameter int unsigned N          = 4,
    parameter int unsigned M          = 8,
    parameter int unsigned C          = 1,
    parameter int unsigned O_BITS     = 4,
    parameter int unsigned FIFO_DEPTH = N + 2,
    localparam int unsigned C_BITS    = (C < 2) ? 1 : $clog2(C)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    thresholding_stream_ctrl_if.slave  s_axis,
    thresholding_stream_ctrl_if.master m_axis,
    output logic                  core_rst,
    output logic                  core_en,
    output logic                  core_ivld,
    output logic [C_BITS-1:0]     core_icnl,
    output logic [M-1:0]          core_idat,
    input  logic                  core_ovld,
    input  logic [C_BITS-1:0]     core_ocnl,
    input  logic [O_BITS-1:0]     core_odat,
    output logic                  err_cnl,
    output logic                  err_ovf
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [C_BITS-1:0] LAST_CNL = C_BITS'(C - 1);

    logic                  sync_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      occ_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [C_BITS-1:0]     in_cnl_q;
    logic [C_BITS-1:0]     exp_cnl_q;
    logic [O_BITS-1:0]     mem_q [FIFO_DEPTH];
    logic                  acc;
    logic                  pop;
    logic                  push;
    logic                  full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // With C==1 the wrap point is 0, so the index stays constant 0.
    function automatic logic [C_BITS-1:0] cnl_inc(input logic [C_BITS-1:0] c);
        return (c == LAST_CNL) ? '0 : c + C_BITS'(1);
    endfunction

    // Handshakes, credit gate and core feed; all derived from registered state.
    assign s_axis.tready = !core_rst && (cnt_q < DEPTH_C);
    assign acc           = s_axis.tvalid && s_axis.tready;
    assign pop           = m_axis.tvalid && m_axis.tready;
    assign full          = (occ_q == DEPTH_C);
    assign push          = core_ovld && !full;
    assign m_axis.tvalid = (occ_q != '0);
    assign m_axis.tdata  = mem_q[rd_ptr_q];
    assign core_ivld     = acc;
    assign core_idat     = s_axis.tdata;
    assign core_icnl     = in_cnl_q;

    // Two-flop release synchroniser: core leaves reset on the 2nd edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            core_rst <= 1'b1;
            core_en  <= 1'b0;
        end else begin
            sync_q   <= 1'b1;
            core_rst <= !sync_q;
            core_en  <= sync_q;
        end
    end

    // Credits: beats inside the core pipeline plus beats waiting in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (acc && !pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (!acc && pop && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Input channel stamp, advancing once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnl_q <= '0;
        end else if (acc) begin
            in_cnl_q <= cnl_inc(in_cnl_q);
        end
    end

    // Result FIFO: fall-through head, registered occupancy, no bypass path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= core_odat;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + CNT_W'(1);
            end else if (!push && pop) begin
                occ_q <= occ_q - CNT_W'(1);
            end
        end
    end

    // Sticky integrity flags: out-of-order channel and result arriving on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnl_q <= '0;
            err_cnl   <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (core_ovld) begin
            exp_cnl_q <= cnl_inc(exp_cnl_q);
            if (core_ocnl != exp_cnl_q) begin
                err_cnl <= 1'b1;
            end
            if (full) begin
                err_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_thresholding_stream_ctrl.sv
// Bench for thresholding_stream_ctrl: a C=3 and a C=1 instance share one
// stimulus stream and one cycle-level expectation queue.
`timescale 1ns/1ps
module tb_thresholding_stream_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned M  = 8;
    localparam int unsigned OB = 4;
    localparam int unsigned FD = 6;
    localparam int unsigned C  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    thresholding_stream_ctrl_if #(.W(M))  s_if ();
    thresholding_stream_ctrl_if #(.W(OB)) m_if ();
    thresholding_stream_ctrl_if #(.W(M))  s1_if ();
    thresholding_stream_ctrl_if #(.W(OB)) m1_if ();

    assign s1_if.tvalid = s_if.tvalid;
    assign s1_if.tdata  = s_if.tdata;
    assign m1_if.tready = m_if.tready;

    logic       core_rst, core_en, core_ivld, core_ovld, err_cnl, err_ovf;
    logic [1:0] core_icnl, core_ocnl;
    logic [7:0] core_idat;
    logic [3:0] core_odat;
    logic       core_rst1, core_en1, core_ivld1, core_ovld1, err_cnl1, err_ovf1;
    logic [0:0] core_icnl1, core_ocnl1;
    logic [7:0] core_idat1;
    logic [3:0] core_odat1;

    thresholding_stream_ctrl #(.N(N), .M(M), .C(C), .O_BITS(OB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
        .core_rst(core_rst), .core_en(core_en), .core_ivld(core_ivld),
        .core_icnl(core_icnl), .core_idat(core_idat), .core_ovld(core_ovld),
        .core_ocnl(core_ocnl), .core_odat(core_odat),
        .err_cnl(err_cnl), .err_ovf(err_ovf));

    thresholding_stream_ctrl #(.N(N), .M(M), .C(1), .O_BITS(OB), .FIFO_DEPTH(FD)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1_if), .m_axis(m1_if),
        .core_rst(core_rst1), .core_en(core_en1), .core_ivld(core_ivld1),
        .core_icnl(core_icnl1), .core_idat(core_idat1), .core_ovld(core_ovld1),
        .core_ocnl(core_ocnl1), .core_odat(core_odat1),
        .err_cnl(err_cnl1), .err_ovf(err_ovf1));

    // Thresholds at -112, -96, ... : result = number of thresholds at or below x.
    function automatic logic [3:0] thr(input logic [7:0] x);
        return 4'((int'($signed(x)) + 128) / 16);
    endfunction

    // Core stand-ins: N-stage pipelines with optional fault overrides on the C=3 side.
    bit       pv [N];
    bit [1:0] pc [N];
    bit [7:0] pd [N];
    bit       pv1 [N];
    bit [0:0] pc1 [N];
    bit [7:0] pd1 [N];
    bit       frc_ovld = 1'b0;
    bit       frc_cnl_en = 1'b0;
    bit [1:0] frc_cnl = 2'd0;

    always @(posedge clk) begin
        if (core_rst) begin
            for (int i = 0; i < int'(N); i++) pv[i] <= 1'b0;
        end else if (core_en) begin
            pv[0] <= core_ivld; pc[0] <= core_icnl; pd[0] <= core_idat;
            for (int i = 1; i < int'(N); i++) begin
                pv[i] <= pv[i-1]; pc[i] <= pc[i-1]; pd[i] <= pd[i-1];
            end
        end
    end

    always @(posedge clk) begin
        if (core_rst1) begin
            for (int i = 0; i < int'(N); i++) pv1[i] <= 1'b0;
        end else if (core_en1) begin
            pv1[0] <= core_ivld1; pc1[0] <= core_icnl1; pd1[0] <= core_idat1;
            for (int i = 1; i < int'(N); i++) begin
                pv1[i] <= pv1[i-1]; pc1[i] <= pc1[i-1]; pd1[i] <= pd1[i-1];
            end
        end
    end

    assign core_ovld  = frc_ovld | pv[N-1];
    assign core_ocnl  = frc_cnl_en ? frc_cnl : pc[N-1];
    assign core_odat  = thr(pd[N-1]);
    assign core_ovld1 = pv1[N-1];
    assign core_ocnl1 = pc1[N-1];
    assign core_odat1 = thr(pd1[N-1]);

    // Expected results: value plus the first cycle it may show on m_axis.
    typedef struct { logic [3:0] dat; int avail; } exp_t;
    exp_t q[$];

    typedef struct { logic [7:0] din; logic [1:0] cnl; logic [3:0] dout; } vec_t;
    vec_t tab [7];

    int total = 0, bad = 0;
    int cyc = 0, rel = 0;
    int acc_n = 0, ovl_n = 0, dut_acc_n = 0, dut_pop_n = 0;
    bit exp_ecnl = 1'b0, exp_eovf = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expectation model, then model update.
    task automatic sample();
        bit er, ev, acc, pop, live;
        int occ;
        if (!rst_n) begin
            q.delete(); acc_n = 0; ovl_n = 0; exp_ecnl = 1'b0; exp_eovf = 1'b0;
        end
        live = rst_n && (rel >= 2);
        er   = live && (q.size() < int'(FD));
        ev   = (q.size() > 0) && (cyc >= q[0].avail);
        chk("s_ready", 32'(s_if.tready), 32'(er));
        chk("s_ready_c1", 32'(s1_if.tready), 32'(er));
        chk("m_valid", 32'(m_if.tvalid), 32'(ev));
        chk("m_valid_c1", 32'(m1_if.tvalid), 32'(ev));
        if (ev) begin
            chk("m_data", 32'(m_if.tdata), 32'(q[0].dat));
            chk("m_data_c1", 32'(m1_if.tdata), 32'(q[0].dat));
        end
        chk("core_rst", 32'(core_rst), 32'(!live));
        chk("core_en", 32'(core_en), 32'(live));
        acc = s_if.tvalid && er;
        chk("core_ivld", 32'(core_ivld), 32'(acc));
        chk("core_ivld_c1", 32'(core_ivld1), 32'(acc));
        if (acc) begin
            chk("core_icnl", 32'(core_icnl), 32'(acc_n % int'(C)));
            chk("core_icnl_c1", 32'(core_icnl1), 32'd0);
            chk("core_idat", 32'(core_idat), 32'(s_if.tdata));
        end
        chk("err_cnl", 32'(err_cnl), 32'(exp_ecnl));
        chk("err_ovf", 32'(err_ovf), 32'(exp_eovf));
        chk("err_c1", {30'd0, err_cnl1, err_ovf1}, 32'd0);
        occ = 0;
        foreach (q[i]) if (q[i].avail <= cyc) occ++;
        if (rst_n && core_ovld) begin
            if (int'(core_ocnl) != ovl_n % int'(C)) exp_ecnl = 1'b1;
            if (occ == int'(FD)) exp_eovf = 1'b1;
            ovl_n++;
        end
        if (s_if.tvalid && s_if.tready) dut_acc_n++;
        if (m_if.tvalid && m_if.tready) dut_pop_n++;
        pop = ev && m_if.tready;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{dat: thr(s_if.tdata), avail: cyc + int'(N) + 1});
            acc_n++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        rel = !rst_n ? 0 : ((rel < 2) ? rel + 1 : 2);
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(2);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_s_ready"}, 32'(s_if.tready), 32'd0);
        chk({nm, "_m_valid"}, 32'(m_if.tvalid), 32'd0);
        chk({nm, "_m_valid_c1"}, 32'(m1_if.tvalid), 32'd0);
        chk({nm, "_ivld"}, 32'(core_ivld), 32'd0);
        chk({nm, "_core_rst"}, 32'(core_rst), 32'd1);
        chk({nm, "_core_en"}, 32'(core_en), 32'd0);
        chk({nm, "_err"}, {30'd0, err_cnl, err_ovf}, 32'd0);
    endtask

    int a0, p0;

    initial begin
        tab[0] = '{8'h00, 2'd0, 4'h8};
        tab[1] = '{8'h7f, 2'd1, 4'hf};
        tab[2] = '{8'h80, 2'd2, 4'h0};
        tab[3] = '{8'h35, 2'd0, 4'hb};
        tab[4] = '{8'hc2, 2'd1, 4'h4};
        tab[5] = '{8'hff, 2'd2, 4'h7};
        tab[6] = '{8'h10, 2'd0, 4'h9};
        s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;

        // T1: power-on reset, release timing, then an asynchronous mid-cycle reset
        ticks(2);
        chk_reset_vals("t1_por");
        rst_n = 1'b1;
        tick();
        chk("t1_rdy_edge1", 32'(s_if.tready), 32'd0);
        tick();
        chk("t1_rdy_edge2", 32'(s_if.tready), 32'd1);
        s_if.tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t1_mid");
        s_if.tvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(2);

        // T2: back-to-back table beats; C=3 channels cycle, C=1 stays 0, results at +5
        for (int k = 0; k < 13; k++) begin
            s_if.tvalid = (k < 7);
            s_if.tdata  = (k < 7) ? tab[k].din : 8'h00;
            @(negedge clk);
            if (k < 7) begin
                chk("t2_icnl", 32'(core_icnl), 32'(tab[k].cnl));
                chk("t2_icnl_c1", 32'(core_icnl1), 32'd0);
            end
            if (k >= 5 && k < 12) begin
                chk("t2_mvalid", 32'(m_if.tvalid), 32'd1);
                chk("t2_mdata", 32'(m_if.tdata), 32'(tab[k-5].dout));
            end
            sample();
            @(posedge clk);
            rel = !rst_n ? 0 : ((rel < 2) ? rel + 1 : 2);
            cyc++;
            #1;
        end
        s_if.tvalid = 1'b0;
        ticks(2);

        // T3: backpressure admits exactly FD beats, then drains them all
        a0 = dut_acc_n;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_if.tdata = 8'($urandom);
            tick();
        end
        chk("t3_accepted", 32'(dut_acc_n - a0), 32'(FD));
        chk("t3_rdy_low", 32'(s_if.tready), 32'd0);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        p0 = dut_pop_n;
        ticks(12);
        chk("t3_popped", 32'(dut_pop_n - p0), 32'(FD));
        chk("t3_rdy_back", 32'(s_if.tready), 32'd1);

        // T4: at FD-1 credits, simultaneous accept and pop keep the count steady
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < int'(FD) - 1; i++) begin
            s_if.tdata = 8'($urandom);
            tick();
        end
        s_if.tvalid = 1'b0;
        ticks(8);
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_if.tdata = 8'($urandom);
            tick();
            chk("t4_cnt", 32'(dut.cnt_q), 32'(FD - 1));
        end
        s_if.tvalid = 1'b0;
        ticks(12);

        // T6: reset with 3 beats in the core and 2 in the FIFO discards all of them
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.tdata = 8'($urandom);
            tick();
        end
        s_if.tvalid = 1'b0;
        tick();
        chk("t6_buffered", 32'(dut.occ_q), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk("t6_mvalid_now", 32'(m_if.tvalid), 32'd0);
        tick();
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        p0 = dut_pop_n;
        ticks(15);
        chk("t6_no_stale", 32'(dut_pop_n - p0), 32'd0);

        // T5: channel fault and overflow fault set their sticky flags
        s_if.tvalid = 1'b1; s_if.tdata = 8'h42;
        tick();
        s_if.tvalid = 1'b0;
        frc_cnl_en = 1'b1; frc_cnl = 2'd2;
        ticks(int'(N) + 2);
        frc_cnl_en = 1'b0;
        chk("t5_err_cnl", 32'(err_cnl), 32'd1);
        ticks(5);
        chk("t5_err_cnl_sticky", 32'(err_cnl), 32'd1);
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        ticks(10);
        s_if.tvalid = 1'b0;
        ticks(8);
        chk("t5_full", 32'(m_if.tvalid), 32'd1);
        frc_ovld = 1'b1;
        tick();
        frc_ovld = 1'b0;
        tick();
        chk("t5_err_ovf", 32'(err_ovf), 32'd1);
        m_if.tready = 1'b1;
        ticks(12);
        do_reset();
        chk("t5_err_cleared", {30'd0, err_cnl, err_ovf}, 32'd0);

        // Random traffic against the expectation model
        for (int i = 0; i < 1500; i++) begin
            s_if.tvalid = 1'($urandom_range(0, 1));
            s_if.tdata  = 8'($urandom);
            m_if.tready = ($urandom_range(0, 9) < 7);
            tick();
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        ticks(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
